// File: rtl/ntt_buffer_ram_responder_if.sv
// Buffer-RAM bus between the NTT controller/host side and the banked coefficient buffer.
// Latency: n/a (wiring only); read data lags the sampled address by READ_LATENCY cycles.
// Backpressure: host requests are qualified by host_req_ready; engine side never stalls.
interface ntt_buffer_ram_responder_if #(
    parameter int E      = 8,
    parameter int FSIZE  = 64,
    parameter int ADDR_W = 5
);
    localparam int W = E * FSIZE;

    // engine (NTT/INTT controller) side
    logic              eng_working;
    logic [ADDR_W-1:0] eng_raddr;
    logic [ADDR_W-1:0] eng_waddr;
    logic              eng_wren;
    logic [W-1:0]      eng_wdata;
    logic [W-1:0]      eng_rdata;

    // host load/unload side
    logic              host_req_valid;
    logic              host_req_ready;
    logic              host_req_we;
    logic [ADDR_W-1:0] host_req_addr;
    logic [W-1:0]      host_req_wdata;
    logic              host_rsp_valid;
    logic [W-1:0]      host_rsp_rdata;

    // status
    logic              owner_engine;
    logic              err_eng_wr_idle;
    logic              err_clr;

    modport master (
        output eng_working, eng_raddr, eng_waddr, eng_wren, eng_wdata,
        output host_req_valid, host_req_we, host_req_addr, host_req_wdata,
        output err_clr,
        input  eng_rdata, host_req_ready, host_rsp_valid, host_rsp_rdata,
        input  owner_engine, err_eng_wr_idle
    );

    modport slave (
        input  eng_working, eng_raddr, eng_waddr, eng_wren, eng_wdata,
        input  host_req_valid, host_req_we, host_req_addr, host_req_wdata,
        input  err_clr,
        output eng_rdata, host_req_ready, host_rsp_valid, host_rsp_rdata,
        output owner_engine, err_eng_wr_idle
    );
endinterface

// File: rtl/ntt_buffer_ram_responder.sv
// Banked coefficient buffer shared by the NTT engine and a host load/unload port (option macro: NTT_BUF_FWD_EN).
// Latency: READ_LATENCY cycles from address sample to eng_rdata / host_rsp_rdata; writes visible to the next read.
// Backpressure: engine never stalls; host_req_ready drops combinationally whenever the engine works or owns the RAM.
module ntt_buffer_ram_responder #(
    parameter int E            = 8,
    parameter int FSIZE        = 64,
    parameter int ADDR_W       = 5,
    parameter int READ_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    ntt_buffer_ram_responder_if.slave bus
);
    localparam int W     = E * FSIZE;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY);

    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(READ_LATENCY - 1);

    // ownership states
    localparam logic [1:0] ST_HOST   = 2'd0;
    localparam logic [1:0] ST_ENGINE = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic             owner_engine_q, owner_engine_d;
    logic             err_q, err_d;

    logic [W-1:0]            rd_dat_q [READ_LATENCY];
    logic [W-1:0]            rd_dat_d [READ_LATENCY];
    logic [READ_LATENCY-1:0] rd_vld_q, rd_vld_d;

    logic [W-1:0] mem [DEPTH];

    logic              owner_state;
    logic              host_rdy;
    logic              host_acc;
    logic              host_rd_acc;
    logic              host_wr_acc;
    logic              eng_wr_acc;
    logic              eng_wr_idle;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [W-1:0]      wr_dat;
    logic [ADDR_W-1:0] rd_addr;
    logic [W-1:0]      rd_raw;

    // Engine owns the port in ENGINE and DRAIN; the host only in HOST with no start pending.
    assign owner_state = (state_q != ST_HOST);
    assign host_rdy    = (state_q == ST_HOST) && !bus.eng_working;
    assign host_acc    = bus.host_req_valid && host_rdy;
    assign host_rd_acc = host_acc && !bus.host_req_we;
    assign host_wr_acc = host_acc && bus.host_req_we;

    // Engine writes land only while it owns the memory; a write while idle is dropped and flagged.
    assign eng_wr_acc  = owner_state && bus.eng_wren;
    assign eng_wr_idle = (state_q == ST_HOST) && !bus.eng_working && bus.eng_wren;

    // Single write port: engine and host writes are mutually exclusive by ownership.
    assign wr_en   = eng_wr_acc || host_wr_acc;
    assign wr_addr = eng_wr_acc ? bus.eng_waddr : bus.host_req_addr;
    assign wr_dat  = eng_wr_acc ? bus.eng_wdata : bus.host_req_wdata;

    // Single read port: the owner's address is sampled every cycle.
    assign rd_addr = owner_state ? bus.eng_raddr : bus.host_req_addr;

`ifdef NTT_BUF_FWD_EN
    // Same-row read and write in one cycle returns the data being written.
    assign rd_raw = (wr_en && (wr_addr == rd_addr)) ? wr_dat : mem[rd_addr];
`else
    // Same-row read and write in one cycle returns the old contents.
    assign rd_raw = mem[rd_addr];
`endif

    // Ownership FSM: HOST -> ENGINE on start, ENGINE -> DRAIN on stop, DRAIN holds READ_LATENCY cycles.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_HOST: begin
                if (bus.eng_working) begin
                    state_d = ST_ENGINE;
                end
            end
            ST_ENGINE: begin
                if (!bus.eng_working) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                if (bus.eng_working) begin
                    state_d = ST_ENGINE;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = ST_HOST;
                end else begin
                    drain_cnt_d = drain_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_HOST;
            end
        endcase
    end

    // Registered ownership flag follows the next state so it rises one cycle after eng_working.
    always_comb begin
        owner_engine_d = (state_d != ST_HOST);
    end

    // Sticky idle-write error; clear wins over a same-cycle set.
    always_comb begin
        err_d = err_q;
        if (bus.err_clr) begin
            err_d = 1'b0;
        end else if (eng_wr_idle) begin
            err_d = 1'b1;
        end
    end

    // Read data/valid delay line: stage 0 samples the RAM, the last stage drives the outputs.
    always_comb begin
        rd_vld_d    = '0;
        rd_vld_d[0] = host_rd_acc;
        rd_dat_d[0] = rd_raw;
        for (int i = 1; i < READ_LATENCY; i++) begin
            rd_vld_d[i] = rd_vld_q[i-1];
            rd_dat_d[i] = rd_dat_q[i-1];
        end
    end

    // Control and read-pipeline state with async reset; in-flight host responses are discarded.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= ST_HOST;
            drain_cnt_q    <= '0;
            owner_engine_q <= 1'b0;
            err_q          <= 1'b0;
            rd_vld_q       <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                rd_dat_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            drain_cnt_q    <= drain_cnt_d;
            owner_engine_q <= owner_engine_d;
            err_q          <= err_d;
            rd_vld_q       <= rd_vld_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                rd_dat_q[i] <= rd_dat_d[i];
            end
        end
    end

    // Row storage: no reset so contents survive a mid-transform reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign bus.host_req_ready  = host_rdy;
    assign bus.eng_rdata       = rd_dat_q[READ_LATENCY-1];
    assign bus.host_rsp_rdata  = rd_dat_q[READ_LATENCY-1];
    assign bus.host_rsp_valid  = rd_vld_q[READ_LATENCY-1];
    assign bus.owner_engine    = owner_engine_q;
    assign bus.err_eng_wr_idle = err_q;

endmodule

// File: doc/ntt_buffer_ram_responder.md
# ntt_buffer_ram_responder

Banked coefficient buffer that serves the NTT/INTT controller's buffer-RAM interface. It accepts the controller's read address, write address, write enable and E-lane write data, and returns E-lane read data after a fixed latency. A second, host-side request/response port loads polynomials before a transform and unloads them after it. An ownership FSM arbitrates between the two ports so the host never disturbs a running transform.

## Interface

**Parameters**
- `E`, 8: lanes per row (power of two).
- `FSIZE`, 64: bits per coefficient.
- `ADDR_W`, logN-logE: row address width; depth is 2^ADDR_W rows.
- `READ_LATENCY`, 2: cycles from address sample to `eng_rdata` / `host_rsp_rdata` valid; must be ≥1.

**Ports** (`clk` single clock; `rstn` asynchronous, active-low)
- `clk` in 1: clock.
- `rstn` in 1: async active-low reset.
- `eng_working` in 1: controller busy flag; requests engine ownership.
- `eng_raddr` in ADDR_W: engine read row.
- `eng_waddr` in ADDR_W: engine write row.
- `eng_wren` in 1: engine write enable.
- `eng_wdata` in E*FSIZE: engine write row; lane k at `[FSIZE*k +: FSIZE]`.
- `eng_rdata` out E*FSIZE: read row for the engine.
- `host_req_valid` in 1: host request.
- `host_req_ready` out 1: host request accepted this cycle.
- `host_req_we` in 1: 1 = write, 0 = read.
- `host_req_addr` in ADDR_W: host row.
- `host_req_wdata` in E*FSIZE: host write row.
- `host_rsp_valid` out 1: host read data valid.
- `host_rsp_rdata` out E*FSIZE: host read row.
- `owner_engine` out 1: 1 while the engine owns the memory.
- `err_eng_wr_idle` out 1: sticky; set by an engine write outside engine ownership.
- `err_clr` in 1: clears `err_eng_wr_idle`.

## Operation
- **FSM states.**
  - HOST (reset state): the host drives the memory port.
  - ENGINE: the engine drives the memory port.
  - DRAIN: the engine's last writes settle and host responses finish.
- **Transitions.**
  - HOST→ENGINE on the first clock edge with `eng_working`=1.
  - ENGINE→DRAIN on the first edge with `eng_working`=0.
  - DRAIN→HOST after READ_LATENCY cycles in DRAIN.
  - DRAIN→ENGINE if `eng_working` reasserts during DRAIN.
- **Memory ports.** One read port and one write port, each E*FSIZE wide.
  - In ENGINE, the read port takes `eng_raddr` every cycle.
  - In ENGINE and DRAIN, the write port takes `eng_waddr`/`eng_wdata` when `eng_wren`=1.
- **Host ready.** `host_req_ready` = (state==HOST) & !`eng_working`. This is combinational, so the host is blocked in the same cycle the engine starts.
- **Host requests.**
  - An accepted host write commits at that edge.
  - An accepted host read enters a READ_LATENCY-deep valid pipeline.
  - Host reads already in flight when ENGINE is entered still complete, with correct data.
- **Read data.** `eng_rdata` is the memory read-port output every cycle, whoever issued the read. `host_rsp_rdata` equals the same data, qualified by `host_rsp_valid`.
- **Read/write collision** (same row read and written in the same cycle): the read returns the old data, unless forwarding is enabled (see Configuration).
- **Engine write outside ownership.** `eng_wren`=1 in HOST with `eng_working`=0 is dropped and sets `err_eng_wr_idle`.
  - `err_clr` has priority over a simultaneous set.
- **Address width.** Addresses index modulo 2^ADDR_W; there is no bounds error.

## Timing
- **Reset values.**
  - State HOST.
  - `owner_engine`=0, `host_rsp_valid`=0, `err_eng_wr_idle`=0.
  - `eng_rdata`=0 and `host_rsp_rdata`=0.
  - Read pipeline valid bits cleared.
  - Memory contents undefined.
- **Read latency.** An address sampled at edge t gives data at edge t+READ_LATENCY.
  - With the default of 2, a read issued in cycle 0 shows valid data in cycle 2.
- **Writes** are visible to reads issued at the next edge or later.
- **`owner_engine`** is registered. It is 1 in ENGINE and DRAIN, and rises one cycle after `eng_working` rises.
- **Reset mid-transform.** The FSM returns to HOST, in-flight host responses are discarded, and memory is not cleared.
- **Throughput.** One engine read plus one engine write per cycle, with no stalls.

## Configuration
- **`NTT_BUF_FWD_EN`**
  - Defined: a same-cycle same-row read and write returns the new write data (write-to-read forwarding for both ports). The forwarded data appears after the same READ_LATENCY.
  - Undefined: the read returns the old contents (read-before-write). No forwarding logic is built.

## Test plan
- **Host load/unload.** Host writes row 5 = lanes 0..7 holding 1..8, then reads row 5 → `host_rsp_valid` exactly 2 cycles after acceptance, with the same data.
- **Ownership handoff.**
  - Assert `eng_working` while the host is sending a request → `host_req_ready`=0 that same cycle.
  - `owner_engine`=1 on the next cycle.
  - A host read accepted one cycle earlier still returns correct data.
- **Engine streaming.** Engine reads rows 0..31 back-to-back → `eng_rdata` returns row k in cycle k+2. Engine writes of rows 31..0 are readable by the host after DRAIN (2 cycles).
- **Collision.** Row 3 holds A; engine writes B to row 3 and reads row 3 in the same cycle → returns A with the macro undefined, B with `NTT_BUF_FWD_EN` defined.
- **Error flag.** `eng_wren`=1 while in HOST → `err_eng_wr_idle`=1 and memory unchanged; `err_clr` → flag 0 on the next cycle.
- **Async reset during ENGINE.** Pulse `rstn` low → `owner_engine`=0 and `host_rsp_valid`=0 immediately; after release, `host_req_ready`=1.
